// File: rtl/instruction_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle for the decode stage.
interface instruction_decode_stage_if #(
   parameter int XLEN     = 32,
   parameter int PC_WIDTH = 32
);
   logic                flush;
   logic                in_valid;
   logic                in_ready;
   logic [31:0]         instruction;
   logic [PC_WIDTH-1:0] pc_in;
   logic                out_valid;
   logic                out_ready;
   logic [6:0]          opcode;
   logic [4:0]          rd;
   logic [2:0]          funct3;
   logic [4:0]          rs1_address;
   logic [4:0]          rs2_address;
   logic [6:0]          funct7;
   logic [XLEN-1:0]     immediate;
   logic                opcode_c_mode;
   logic                illegal;
   logic [PC_WIDTH-1:0] pc_out;

   // upstream/downstream environment view
   modport master (
      output flush, in_valid, instruction, pc_in, out_ready,
      input  in_ready, out_valid, opcode, rd, funct3, rs1_address, rs2_address,
             funct7, immediate, opcode_c_mode, illegal, pc_out
   );

   // decode stage view
   modport slave (
      input  flush, in_valid, instruction, pc_in, out_ready,
      output in_ready, out_valid, opcode, rd, funct3, rs1_address, rs2_address,
             funct7, immediate, opcode_c_mode, illegal, pc_out
   );
endinterface

// File: rtl/instruction_decode_stage.sv
// Registered RV32I + RVC-subset decode stage with optional 2-entry skid buffer.
module instruction_decode_stage #(
   parameter int XLEN     = 32,
   parameter int PC_WIDTH = 32,
   parameter bit ENABLE_C = 1'b1,
   parameter bit SKID     = 1'b1
) (
   input logic                       clk,
   input logic                       rst,
   instruction_decode_stage_if.slave bus
);

   typedef struct packed {
      logic [6:0]          opcode;
      logic [4:0]          rd;
      logic [2:0]          funct3;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [6:0]          funct7;
      logic [XLEN-1:0]     imm;
      logic                c_mode;
      logic                illegal;
      logic [PC_WIDTH-1:0] pc;
   } entry_t;

   entry_t      dec;
   logic [31:0] imm32;
   logic [31:0] w;
   logic [15:0] h;

   entry_t out_q, out_d, skid_q, skid_d;
   logic   out_valid_q, out_valid_d;
   logic   skid_valid_q, skid_valid_d;
   logic   in_ready_q, in_ready_d;
   logic   in_ready, accept, pop;

   // Decode the incoming fetch word; fields not used by a format stay zero.
   always_comb begin
      dec      = '0;
      imm32    = '0;
      w        = bus.instruction;
      h        = bus.instruction[15:0];
      dec.pc   = bus.pc_in;
      if (w[1:0] == 2'b11) begin
         dec.opcode = w[6:0];
         case (w[6:2])
            5'b01101, 5'b00101: begin
               dec.rd = w[11:7];
               imm32  = {w[31:12], 12'b0};
            end
            5'b11011: begin
               dec.rd = w[11:7];
               imm32  = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            end
            5'b11001, 5'b00000, 5'b00100: begin
               dec.rd     = w[11:7];
               dec.rs1    = w[19:15];
               dec.funct3 = w[14:12];
               imm32      = {{20{w[31]}}, w[31:20]};
            end
            5'b01000: begin
               dec.rs1    = w[19:15];
               dec.rs2    = w[24:20];
               dec.funct3 = w[14:12];
               imm32      = {{20{w[31]}}, w[31:25], w[11:7]};
            end
            5'b11000: begin
               dec.rs1    = w[19:15];
               dec.rs2    = w[24:20];
               dec.funct3 = w[14:12];
               imm32      = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            end
            5'b01100: begin
               dec.rd     = w[11:7];
               dec.rs1    = w[19:15];
               dec.rs2    = w[24:20];
               dec.funct3 = w[14:12];
               dec.funct7 = w[31:25];
            end
            default: dec.illegal = 1'b1;
         endcase
      end else begin
         // 16-bit word: illegal unless it matches a supported expansion
         dec.c_mode  = 1'b1;
         dec.illegal = 1'b1;
         if (ENABLE_C) begin
            case ({h[1:0], h[15:13]})
               5'b00_010: begin // c.lw -> lw
                  dec.illegal = 1'b0;
                  dec.opcode  = 7'h03;
                  dec.rd      = {2'b01, h[4:2]};
                  dec.rs1     = {2'b01, h[9:7]};
                  dec.funct3  = 3'd2;
                  imm32       = {25'b0, h[5], h[12:10], h[6], 2'b0};
               end
               5'b00_110: begin // c.sw -> sw
                  dec.illegal = 1'b0;
                  dec.opcode  = 7'h23;
                  dec.rs2     = {2'b01, h[4:2]};
                  dec.rs1     = {2'b01, h[9:7]};
                  dec.funct3  = 3'd2;
                  imm32       = {25'b0, h[5], h[12:10], h[6], 2'b0};
               end
               5'b01_000, 5'b01_010: begin // c.addi / c.li -> addi
                  dec.illegal = 1'b0;
                  dec.opcode  = 7'h13;
                  dec.rd      = h[11:7];
                  dec.rs1     = h[14] ? 5'd0 : h[11:7];
                  imm32       = {{27{h[12]}}, h[6:2]};
               end
               5'b01_101: begin // c.j -> jal x0
                  dec.illegal = 1'b0;
                  dec.opcode  = 7'h6F;
                  imm32       = {{21{h[12]}}, h[8], h[10:9], h[6], h[7], h[2], h[11], h[5:3], 1'b0};
               end
               5'b10_100: begin // c.mv / c.add -> add; rs2==0 encodings are not supported
                  if (h[6:2] != 5'd0) begin
                     dec.illegal = 1'b0;
                     dec.opcode  = 7'h33;
                     dec.rd      = h[11:7];
                     dec.rs1     = h[12] ? h[11:7] : 5'd0;
                     dec.rs2     = h[6:2];
                  end
               end
               default: ;
            endcase
         end
      end
      dec.imm = XLEN'($signed(imm32));
   end

   // SKID=1 keeps in_ready purely registered; SKID=0 trades that for one less entry.
   assign in_ready = SKID ? in_ready_q : (!out_valid_q || bus.out_ready);
   assign accept   = bus.in_valid && in_ready && !bus.flush;
   assign pop      = out_valid_q && bus.out_ready;

   // Next-state for the output register and skid entry (FIFO order: skid drains first).
   always_comb begin
      out_d        = out_q;
      skid_d       = skid_q;
      out_valid_d  = out_valid_q;
      skid_valid_d = skid_valid_q;
      if (bus.flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (SKID) begin
         if (!out_valid_q || pop) begin
            if (skid_valid_q) begin
               out_d        = skid_q;
               out_valid_d  = 1'b1;
               skid_valid_d = 1'b0;
            end else begin
               out_valid_d = accept;
               if (accept) out_d = dec;
            end
         end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
         end
      end else begin
         if (accept) begin
            out_d       = dec;
            out_valid_d = 1'b1;
         end else if (pop) begin
            out_valid_d = 1'b0;
         end
      end
      in_ready_d = !skid_valid_d;
   end

   // State registers; reset clears all held entries and data outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q        <= '0;
         skid_q       <= '0;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         out_q        <= out_d;
         skid_q       <= skid_d;
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign bus.in_ready      = in_ready;
   assign bus.out_valid     = out_valid_q;
   assign bus.opcode        = out_q.opcode;
   assign bus.rd            = out_q.rd;
   assign bus.funct3        = out_q.funct3;
   assign bus.rs1_address   = out_q.rs1;
   assign bus.rs2_address   = out_q.rs2;
   assign bus.funct7        = out_q.funct7;
   assign bus.immediate     = out_q.imm;
   assign bus.opcode_c_mode = out_q.c_mode;
   assign bus.illegal       = out_q.illegal;
   assign bus.pc_out        = out_q.pc;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Randomized bench: 2-deep FIFO reference model plus a mnemonic-level decoder.
module tb_instruction_decode_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   logic [97:0] mq[$];
   bit   last_acc, last_pop;

   instruction_decode_stage_if #(.XLEN(32), .PC_WIDTH(32)) bus ();

   instruction_decode_stage #(.XLEN(32), .PC_WIDTH(32), .ENABLE_C(1'b1), .SKID(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [97:0] obs();
      return {bus.opcode, bus.rd, bus.funct3, bus.rs1_address, bus.rs2_address, bus.funct7,
              bus.immediate, bus.opcode_c_mode, bus.illegal, bus.pc_out};
   endfunction

   // Reference decode by instruction class, immediates built with arithmetic.
   function automatic logic [97:0] ref_dec(input logic [31:0] w, input logic [31:0] pc);
      int op = 0, rd = 0, f3 = 0, rs1 = 0, rs2 = 0, f7 = 0, imm = 0;
      bit cm = 0, ill = 0;
      logic [15:0] h = w[15:0];
      int sgn = w[31] ? 4096 : 0;
      if (w[1:0] == 2'b11) begin
         op = int'(w[6:0]);
         case (w[6:0])
            7'h37, 7'h17: begin rd = int'(w[11:7]); imm = int'(w & 32'hFFFFF000); end
            7'h6F: begin
               rd  = int'(w[11:7]);
               imm = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096 - (w[31] ? 1048576 : 0);
            end
            7'h67, 7'h03, 7'h13: begin
               rd = int'(w[11:7]); rs1 = int'(w[19:15]); f3 = int'(w[14:12]);
               imm = int'(w[31:20]) - sgn;
            end
            7'h23: begin
               rs1 = int'(w[19:15]); rs2 = int'(w[24:20]); f3 = int'(w[14:12]);
               imm = int'(w[31:25]) * 32 + int'(w[11:7]) - sgn;
            end
            7'h63: begin
               rs1 = int'(w[19:15]); rs2 = int'(w[24:20]); f3 = int'(w[14:12]);
               imm = int'(w[11:8]) * 2 + int'(w[30:25]) * 32 + int'(w[7]) * 2048 - sgn;
            end
            7'h33: begin
               rd = int'(w[11:7]); rs1 = int'(w[19:15]); rs2 = int'(w[24:20]);
               f3 = int'(w[14:12]); f7 = int'(w[31:25]);
            end
            default: ill = 1;
         endcase
      end else begin
         int q = int'(h[1:0]);
         int f = int'(h[15:13]);
         cm  = 1;
         ill = 1;
         if (q == 0 && (f == 2 || f == 6)) begin
            ill = 0; op = (f == 2) ? 3 : 35; f3 = 2;
            rs1 = 8 + int'(h[9:7]);
            if (f == 2) rd = 8 + int'(h[4:2]); else rs2 = 8 + int'(h[4:2]);
            imm = int'(h[6]) * 4 + int'(h[12:10]) * 8 + int'(h[5]) * 64;
         end else if (q == 1 && (f == 0 || f == 2)) begin
            ill = 0; op = 19; rd = int'(h[11:7]);
            rs1 = (f == 0) ? rd : 0;
            imm = int'(h[6:2]) - (h[12] ? 32 : 0);
         end else if (q == 1 && f == 5) begin
            ill = 0; op = 111;
            imm = int'(h[5:3]) * 2 + int'(h[11]) * 16 + int'(h[2]) * 32 + int'(h[7]) * 64 +
                  int'(h[6]) * 128 + int'(h[10:9]) * 256 + int'(h[8]) * 1024 - (h[12] ? 2048 : 0);
         end else if (q == 2 && f == 4 && h[6:2] != 0) begin
            ill = 0; op = 51; rd = int'(h[11:7]); rs2 = int'(h[6:2]);
            rs1 = h[12] ? rd : 0;
         end
      end
      return {op[6:0], rd[4:0], f3[2:0], rs1[4:0], rs2[4:0], f7[6:0], imm[31:0], cm, ill, pc};
   endfunction

   function automatic logic [31:0] rand_word();
      logic [31:0] r = $urandom;
      logic [6:0]  ops[9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h23, 7'h63, 7'h33};
      int sel = $urandom_range(0, 9);
      if (sel <= 4) return {r[31:7], ops[$urandom_range(0, 8)]};
      if (sel <= 7) begin
         logic [2:0] f = 3'($urandom_range(0, 7));
         logic [1:0] q = 2'($urandom_range(0, 2));
         return {r[31:16], f, r[12:2], q};
      end
      if (sel == 8) return r;
      return r[0] ? 32'h0 : 32'hFFFF_FFFF;
   endfunction

   // One clock: check against the model mid-cycle, then advance the model.
   task automatic step();
      logic [97:0] e;
      @(negedge clk);
      chk("in_ready", bus.in_ready, mq.size() < 2);
      chk("out_valid", bus.out_valid, mq.size() != 0);
      if (mq.size() != 0) chk("entry", obs(), mq[0]);
      last_acc = bus.in_valid && !bus.flush && mq.size() < 2;
      last_pop = mq.size() != 0 && bus.out_ready && !bus.flush;
      e = ref_dec(bus.instruction, bus.pc_in);
      @(posedge clk);
      #1;
      if (bus.flush) mq.delete();
      else begin
         if (last_pop) void'(mq.pop_front());
         if (last_acc) mq.push_back(e);
      end
   endtask

   task automatic one(input logic [31:0] word, input logic [31:0] pc);
      bus.in_valid = 1'b1; bus.instruction = word; bus.pc_in = pc; bus.out_ready = 1'b1;
      step();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      logic ir;
      int sent, recvd;
      logic [1:0] pat[4] = '{2'b01, 2'b00, 2'b00, 2'b01};
      bus.flush = 0; bus.in_valid = 0; bus.instruction = 0; bus.pc_in = 0; bus.out_ready = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_data", obs(), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // directed decode vectors
      one(32'hFFF30293, 32'h100);
      chk("addi_fields", {bus.opcode, bus.rd, bus.rs1_address, bus.funct3},
          {7'h13, 5'd5, 5'd6, 3'd0});
      chk("addi_imm", bus.immediate, 32'hFFFF_FFFF);
      chk("addi_pc", bus.pc_out, 32'h100);
      one(32'h0000_4188, 32'h104); // c.lw a0,0(a1)
      chk("clw_fields", {bus.opcode, bus.rd, bus.rs1_address, bus.funct3, bus.opcode_c_mode},
          {7'h03, 5'd10, 5'd11, 3'd2, 1'b1});
      chk("clw_imm", bus.immediate, 32'd0);
      one(32'h0000_4588, 32'h106); // c.lw a0,8(a1)
      chk("clw8_imm", bus.immediate, 32'd8);
      one(32'h0000_BFFD, 32'h108);
      chk("cj", {bus.opcode, bus.rd, bus.immediate}, {7'h6F, 5'd0, 32'hFFFF_FFFE});
      one(32'h0000_0000, 32'h10A);
      chk("zero_illegal", {bus.illegal, bus.opcode, bus.opcode_c_mode}, {1'b1, 7'h00, 1'b1});
      one(32'hFFFF_FFFF, 32'h10C);
      chk("ones_illegal", bus.illegal, 1'b1);
      bus.out_ready = 1'b1;
      step();

      // 8-word stream with out_ready 1,0,0,1
      sent = 0; recvd = 0;
      for (int c = 0; c < 40 && (sent < 8 || mq.size() != 0); c++) begin
         bus.in_valid = sent < 8;
         bus.instruction = rand_word();
         bus.pc_in = 32'h200 + 4 * sent;
         bus.out_ready = pat[c % 4][0];
         ir = bus.in_ready;
         bus.out_ready = ~bus.out_ready;
         #1;
         chk("in_ready_comb", bus.in_ready, ir);
         bus.out_ready = ~bus.out_ready;
         step();
         if (last_acc) sent++;
         if (last_pop) recvd++;
      end
      chk("stream_count", recvd, 8);

      // flush with output + skid held and a word presented
      bus.out_ready = 1'b0; bus.in_valid = 1'b1;
      bus.instruction = 32'h0010_0093; bus.pc_in = 32'h300; step();
      bus.pc_in = 32'h304; step();
      chk("pre_flush_full", bus.in_ready, 1'b0);
      bus.flush = 1'b1; bus.pc_in = 32'h308; step();
      bus.flush = 1'b0;
      chk("flush_out_valid", bus.out_valid, 1'b0);
      chk("flush_in_ready", bus.in_ready, 1'b1);
      bus.pc_in = 32'h30C; bus.out_ready = 1'b1; step();
      bus.in_valid = 1'b0;
      chk("post_flush_first", {bus.out_valid, bus.pc_out}, {1'b1, 32'h30C});
      step();

      // random traffic
      for (int c = 0; c < 1500; c++) begin
         bus.in_valid = $urandom_range(0, 9) < 7;
         bus.out_ready = $urandom_range(0, 9) < 6;
         bus.flush = $urandom_range(0, 99) < 3;
         bus.instruction = rand_word();
         bus.pc_in = $urandom;
         step();
      end
      bus.flush = 1'b0;

      // async reset while an entry is held
      bus.in_valid = 1'b1; bus.out_ready = 1'b0; bus.instruction = 32'h0010_0093; bus.pc_in = 32'h400;
      step();
      bus.in_valid = 1'b0;
      chk("pre_rst_valid", bus.out_valid, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_valid", bus.out_valid, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      mq.delete();
      @(posedge clk); #1;
      chk("rst2_in_ready", bus.in_ready, 1'b1);
      chk("rst2_data", {bus.out_valid, obs()}, 0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
